id_stream_gen: RTL

- Character-stream generator for identifier tokens. It is the transmit-side counterpart of the identifier recogniser, which accepts letters followed by digits, one 8-bit ASCII char per clock.
- On each start it emits one token of the form [a-z|A-Z]{L}[0-9]{D}, then an optional separator, over a valid/ready byte interface.
- It drives the recogniser in system tests and bench loops. A per-char expect_match flag gives the scoreboard the recogniser's expected output.

---
 rtl/id_stream_gen_pkg.sv | 44 ++++
 rtl/id_stream_gen_rom.sv | 23 ++
 rtl/id_stream_gen.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/id_stream_gen_pkg.sv
// Shared constants, state encoding and index helpers for the identifier
// token generator and its character ROM.
package id_stream_gen_pkg;

  localparam logic [7:0] ASCII_a  = 8'h61;
  localparam logic [7:0] ASCII_A  = 8'h41;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_SP = 8'h20;

  localparam logic [4:0] LETTER_WRAP = 5'd25;
  localparam logic [3:0] DIGIT_WRAP  = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LET  = 2'd1,
    DIG  = 2'd2,
    SEP  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CLS_NONE   = 2'd0,
    CLS_LETTER = 2'd1,
    CLS_DIGIT  = 2'd2,
    CLS_SEP    = 2'd3
  } char_class_e;

  // Out-of-range start indices fall back to the first symbol of the alphabet.
  function automatic logic [4:0] clamp_letter(input logic [4:0] v);
    return (v > LETTER_WRAP) ? 5'd0 : v;
  endfunction

  function automatic logic [3:0] clamp_digit(input logic [3:0] v);
    return (v > DIGIT_WRAP) ? 4'd0 : v;
  endfunction

  function automatic logic [4:0] next_letter(input logic [4:0] v);
    return (v == LETTER_WRAP) ? 5'd0 : v + 5'd1;
  endfunction

  function automatic logic [3:0] next_digit(input logic [3:0] v);
    return (v == DIGIT_WRAP) ? 4'd0 : v + 4'd1;
  endfunction

endpackage

// File: rtl/id_stream_gen_rom.sv
// Combinational character ROM: maps (class, index, case) to an ASCII byte.
module id_char_rom
  import id_stream_gen_pkg::*;
#(
  parameter logic [7:0] SEP_CHAR = ASCII_SP
) (
  input  char_class_e cls_i,
  input  logic [4:0]  index_i,
  input  logic        upper_i,
  output logic [7:0]  ascii_o
);

  always_comb begin
    ascii_o = 8'h00;
    case (cls_i)
      CLS_LETTER: ascii_o = (upper_i ? ASCII_A : ASCII_a) + {3'b000, index_i};
      CLS_DIGIT:  ascii_o = ASCII_0 + {3'b000, index_i};
      CLS_SEP:    ascii_o = SEP_CHAR;
      default:    ascii_o = 8'h00;
    endcase
  end

endmodule

// File: rtl/id_stream_gen.sv
// Identifier token generator: emits letters, digits and an optional separator
// over a valid/ready byte stream, flagging chars a recogniser should match.
module id_stream_gen
  import id_stream_gen_pkg::*;
#(
  parameter logic [7:0] SEP_CHAR = ASCII_SP,
  parameter bit         EMIT_SEP = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic [3:0] letter_cnt_i,
  input  logic [3:0] digit_cnt_i,
  input  logic [4:0] first_letter_i,
  input  logic [3:0] first_digit_i,
  input  logic       upper_i,
  output logic [7:0] char_o,
  output logic       char_valid_o,
  input  logic       char_ready_i,
  output logic       expect_match_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o
);

  state_e      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [3:0]  dv_q, dv_d;
  logic [3:0]  let_rem_q, let_rem_d;
  logic [3:0]  dig_rem_q, dig_rem_d;
  logic        upper_q, upper_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        xfer;

  char_class_e rom_cls;
  logic [4:0]  rom_index;
  logic [7:0]  rom_ascii;

  id_char_rom #(
    .SEP_CHAR (SEP_CHAR)
  ) u_rom (
    .cls_i   (rom_cls),
    .index_i (rom_index),
    .upper_i (upper_q),
    .ascii_o (rom_ascii)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= 5'd0;
      dv_q      <= 4'd0;
      let_rem_q <= 4'd0;
      dig_rem_q <= 4'd0;
      upper_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      dv_q      <= dv_d;
      let_rem_q <= let_rem_d;
      dig_rem_q <= dig_rem_d;
      upper_q   <= upper_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Every non-IDLE state presents a char, so a transfer is just ready there.
  assign xfer = (state_q != IDLE) && char_ready_i;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    dv_d      = dv_q;
    let_rem_d = let_rem_q;
    dig_rem_d = dig_rem_q;
    upper_d   = upper_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (letter_cnt_i != 4'd0) begin
            state_d   = LET;
            idx_d     = clamp_letter(first_letter_i);
            dv_d      = clamp_digit(first_digit_i);
            let_rem_d = letter_cnt_i;
            dig_rem_d = digit_cnt_i;
            upper_d   = upper_i;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LET: begin
        if (xfer) begin
          idx_d     = next_letter(idx_q);
          let_rem_d = let_rem_q - 4'd1;
          if (let_rem_q == 4'd1) begin
            if (dig_rem_q != 4'd0) begin
              state_d = DIG;
            end else if (EMIT_SEP) begin
              state_d = SEP;
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end
      end
      DIG: begin
        if (xfer) begin
          dv_d      = next_digit(dv_q);
          dig_rem_d = dig_rem_q - 4'd1;
          if (dig_rem_q == 4'd1) begin
            if (EMIT_SEP) begin
              state_d = SEP;
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end
      end
      SEP: begin
        if (xfer) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode registered state only, so they hold while the sink stalls.
  always_comb begin
    char_valid_o   = 1'b0;
    expect_match_o = 1'b0;
    busy_o         = 1'b0;
    rom_cls        = CLS_NONE;
    rom_index      = 5'd0;
    case (state_q)
      LET: begin
        char_valid_o = 1'b1;
        busy_o       = 1'b1;
        rom_cls      = CLS_LETTER;
        rom_index    = idx_q;
      end
      DIG: begin
        char_valid_o   = 1'b1;
        busy_o         = 1'b1;
        expect_match_o = 1'b1;
        rom_cls        = CLS_DIGIT;
        rom_index      = {1'b0, dv_q};
      end
      SEP: begin
        char_valid_o = 1'b1;
        busy_o       = 1'b1;
        rom_cls      = CLS_SEP;
      end
      default: ;
    endcase
  end

  assign char_o = rom_ascii;
  assign done_o = done_q;
  assign err_o  = err_q;

endmodule
